// File: rtl/kv_key_fetch.sv
// Keyvault read client: fetches one key entry dword by dword into an engine's
// local key register and reports done plus a sticky status code.
module kv_key_fetch #(
  parameter int unsigned KV_ENTRY_ADDR_W = 5,
  parameter int unsigned KV_ENTRY_SIZE_W = 4,
  parameter int unsigned DEST_NUM_DWORDS = 12,
  parameter int unsigned DEST_OFFSET_W   = $clog2(DEST_NUM_DWORDS)
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       flush,
  input  logic                       start,
  input  logic [KV_ENTRY_ADDR_W-1:0] start_entry,
  output logic                       ready,
  output logic                       done,
  output logic [7:0]                 error_code,
  output logic [KV_ENTRY_ADDR_W-1:0] kv_read_entry,
  output logic [KV_ENTRY_SIZE_W-1:0] kv_read_offset,
  input  logic [31:0]                kv_rd_data,
  input  logic                       kv_rd_error,
  input  logic                       kv_rd_last,
  output logic                       dest_wr_en,
  output logic [DEST_OFFSET_W-1:0]   dest_wr_offset,
  output logic [31:0]                dest_wr_data,
  output logic                       dest_clear
);

  localparam logic [7:0] ERR_OK        = 8'h00;
  localparam logic [7:0] ERR_READ_FAIL = 8'h01;
  localparam logic [7:0] ERR_SIZE_OVF  = 8'h02;

  // Last destination slot; reaching it without kv_rd_last means the entry is too long.
  localparam logic [KV_ENTRY_SIZE_W-1:0] CNT_MAX = KV_ENTRY_SIZE_W'(DEST_NUM_DWORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                     state;
  logic [KV_ENTRY_ADDR_W-1:0] entry_q;
  logic [KV_ENTRY_SIZE_W-1:0] cnt;
  logic                       in_read;
  logic                       wr_ok;

  assign in_read = (state == READ);
  // A dword is committed only when the keyvault accepts the read and no flush is pending.
  assign wr_ok   = in_read & ~kv_rd_error & ~flush;

  // Fetch sequencer: state, counter, latched entry, status and handshake outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      entry_q    <= '0;
      cnt        <= '0;
      ready      <= 1'b1;
      done       <= 1'b0;
      error_code <= ERR_OK;
    end else if (flush) begin
      state      <= IDLE;
      cnt        <= '0;
      ready      <= 1'b1;
      done       <= 1'b0;
      error_code <= ERR_OK;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            entry_q    <= start_entry;
            error_code <= ERR_OK;
            cnt        <= '0;
            ready      <= 1'b0;
            state      <= READ;
          end
        end
        READ: begin
          if (kv_rd_error) begin
            error_code <= ERR_READ_FAIL;
            done       <= 1'b1;
            state      <= DONE;
          end else if (kv_rd_last) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (cnt == CNT_MAX) begin
            error_code <= ERR_SIZE_OVF;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + KV_ENTRY_SIZE_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Keyvault address is only presented while reading; zero otherwise.
  assign kv_read_entry  = in_read ? entry_q : '0;
  assign kv_read_offset = in_read ? cnt : '0;

  // Destination write path is same-cycle with the keyvault response; bus is zero when idle.
  assign dest_wr_en     = wr_ok;
  assign dest_wr_offset = wr_ok ? cnt[DEST_OFFSET_W-1:0] : '0;
  assign dest_wr_data   = wr_ok ? kv_rd_data : 32'h0;

  // Zeroize on flush, on a rejected read, and in the DONE cycle after a size overflow.
  assign dest_clear = flush
                    | (in_read & kv_rd_error)
                    | ((state == DONE) & (error_code == ERR_SIZE_OVF));

endmodule

// File: tb/tb_kv_key_fetch.sv
// Directed bench for kv_key_fetch with a keyvault model and a write scoreboard.
module tb_kv_key_fetch;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  start_entry = '0;
  logic        ready, done;
  logic [7:0]  error_code;
  logic [4:0]  kv_read_entry;
  logic [3:0]  kv_read_offset;
  logic [31:0] kv_rd_data;
  logic        kv_rd_error, kv_rd_last;
  logic        dest_wr_en;
  logic [3:0]  dest_wr_offset;
  logic [31:0] dest_wr_data;
  logic        dest_clear;

  kv_key_fetch dut (
    .clk(clk), .rst_b(rst_b), .flush(flush), .start(start), .start_entry(start_entry),
    .ready(ready), .done(done), .error_code(error_code),
    .kv_read_entry(kv_read_entry), .kv_read_offset(kv_read_offset),
    .kv_rd_data(kv_rd_data), .kv_rd_error(kv_rd_error), .kv_rd_last(kv_rd_last),
    .dest_wr_en(dest_wr_en), .dest_wr_offset(dest_wr_offset), .dest_wr_data(dest_wr_data),
    .dest_clear(dest_clear)
  );

  always #5 clk = ~clk;

  // Keyvault storage model
  logic [31:0] kv_mem [32][16];
  logic [3:0]  last_off [32];
  logic        lock_en = 1'b0;
  logic [4:0]  lock_entry = '0;
  logic [3:0]  lock_off = '0;

  always_comb begin
    kv_rd_data  = kv_mem[kv_read_entry][kv_read_offset];
    kv_rd_last  = (kv_read_offset == last_off[kv_read_entry]);
    kv_rd_error = lock_en && (kv_read_entry == lock_entry) && (kv_read_offset == lock_off);
  end

  // Destination register model
  logic [31:0] dest_m [12];
  always @(posedge clk) begin
    if (dest_clear) begin
      for (int i = 0; i < 12; i++) dest_m[i] <= 32'h0;
    end else if (dest_wr_en && dest_wr_offset < 4'd12) begin
      dest_m[dest_wr_offset] <= dest_wr_data;
    end
  end

  typedef struct packed {
    logic [3:0]  off;
    logic [31:0] data;
  } wr_t;
  wr_t sb[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one fetch; cycle 0 is the start cycle. -1 disables a cycle argument.
  task automatic fetch(input int ent, input int n_wr, input int done_cyc,
                       input logic [7:0] exp_err, input int clear_cyc,
                       input int restart_at, input bit start_in_done, input int flush_at);
    wr_t w;
    int  done_at = -1;
    int  clears = 0;
    int  clear_at = -1;
    int  writes = 0;
    bit  flushed = 1'b0;
    sb.delete();
    for (int i = 0; i < n_wr; i++) begin
      w.off  = 4'(i);
      w.data = kv_mem[ent][i];
      sb.push_back(w);
    end
    start_entry = 5'(ent);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == restart_at) begin
        start = 1'b1;
        start_entry = 5'(ent ^ 1);
      end
      if (c == flush_at) begin
        flush = 1'b1;
        start = 1'b1;
        start_entry = 5'(ent ^ 1);
      end
      #1;
      if (c == 1) begin
        chk("err_cleared_on_start", 32'(error_code), 32'h0);
        chk("ready_low_in_read", 32'(ready), 32'h0);
      end
      if (dest_wr_en) begin
        writes++;
        if (sb.size() > 0) begin
          w = sb.pop_front();
          chk("wr_offset", 32'(dest_wr_offset), 32'(w.off));
          chk("wr_data", dest_wr_data, w.data);
        end
      end else begin
        chk("idle_wr_data_zero", dest_wr_data, 32'h0);
      end
      if (dest_clear) begin
        clears++;
        clear_at = c;
      end
      if (done) begin
        done_at = c;
        chk("done_error_code", 32'(error_code), 32'(exp_err));
        chk("ready_in_done", 32'(ready), 32'h0);
        if (start_in_done) begin
          start = 1'b1;
          start_entry = 5'(ent ^ 1);
        end
      end
      step();
      start = 1'b0;
      flush = 1'b0;
      if (c == flush_at) begin
        flushed = 1'b1;
        break;
      end
      if (done_at >= 0) break;
    end
    if (flushed) begin
      chk("flush_ready", 32'(ready), 32'h1);
      chk("flush_no_done", 32'(done), 32'h0);
      chk("flush_err", 32'(error_code), 32'h0);
      chk("flush_no_write", 32'(dest_wr_en), 32'h0);
      step();
      chk("flush_start_ignored", 32'(ready), 32'h1);
      chk("flush_no_done2", 32'(done), 32'h0);
    end else begin
      chk("done_cycle", 32'(done_at), 32'(done_cyc));
      chk("after_done_ready", 32'(ready), 32'h1);
      chk("done_one_cycle", 32'(done), 32'h0);
      chk("after_done_no_write", 32'(dest_wr_en), 32'h0);
      chk("err_sticky", 32'(error_code), 32'(exp_err));
    end
    chk("write_count", 32'(writes), 32'(n_wr));
    chk("clear_count", 32'(clears), (clear_cyc < 0) ? 32'h0 : 32'h1);
    chk("clear_cycle", 32'(clear_at), 32'(clear_cyc));
  endtask

  initial begin
    for (int e = 0; e < 32; e++) begin
      last_off[e] = 4'd15;
      for (int o = 0; o < 16; o++) kv_mem[e][o] = 32'h5A00_0000 | 32'(e << 8) | 32'(o);
    end
    for (int o = 0; o < 16; o++) kv_mem[3][o] = 32'hA0 + 32'(o);
    last_off[3] = 4'd11;
    last_off[5] = 4'd7;
    last_off[4] = 4'd11;
    last_off[9] = 4'd11;
    last_off[7] = 4'd15;
    for (int i = 0; i < 12; i++) dest_m[i] = 32'h0;

    // Reset values
    step();
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(error_code), 32'h0);
    chk("rst_wr_en", 32'(dest_wr_en), 32'h0);
    chk("rst_clear", 32'(dest_clear), 32'h0);
    chk("rst_kv_entry", 32'(kv_read_entry), 32'h0);
    chk("rst_kv_offset", 32'(kv_read_offset), 32'h0);
    chk("rst_wr_data", dest_wr_data, 32'h0);
    rst_b = 1'b1;
    step();
    step();

    // Full 12-dword entry
    fetch(3, 12, 13, 8'h00, -1, -1, 1'b0, -1);
    // Short 8-dword entry leaves upper destination slots untouched
    fetch(5, 8, 9, 8'h00, -1, -1, 1'b0, -1);
    for (int i = 8; i < 12; i++) chk("untouched_slot", dest_m[i], 32'hA0 + 32'(i));

    // Use-lock at offset 4
    lock_en = 1'b1;
    lock_entry = 5'd9;
    lock_off = 4'd4;
    fetch(9, 4, 6, 8'h01, 5, -1, 1'b0, -1);
    lock_en = 1'b0;
    step();
    step();
    step();
    chk("read_fail_sticky", 32'(error_code), 32'h01);

    // Entry longer than the destination
    fetch(7, 12, 13, 8'h02, 13, -1, 1'b0, -1);
    for (int i = 0; i < 12; i++) chk("ovf_dest_cleared", dest_m[i], 32'h0);

    // Flush on the 6th READ cycle with a competing start
    fetch(3, 5, -1, 8'h00, 6, -1, 1'b0, 6);

    // Start during READ and in DONE ignored; start right after done accepted
    fetch(5, 8, 9, 8'h00, -1, 3, 1'b1, -1);
    fetch(3, 12, 13, 8'h00, -1, -1, 1'b0, -1);

    // Asynchronous reset mid-fetch
    start_entry = 5'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("midfetch_writing", 32'(dest_wr_en), 32'h1);
    rst_b = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 32'h1);
    chk("midrst_wr_en", 32'(dest_wr_en), 32'h0);
    chk("midrst_kv_entry", 32'(kv_read_entry), 32'h0);
    chk("midrst_kv_offset", 32'(kv_read_offset), 32'h0);
    step();
    rst_b = 1'b1;
    step();
    chk("post_rst_ready", 32'(ready), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kv_key_fetch.md
Name: kv_key_fetch

Overview:
- Keyvault read client that sits inside a crypto engine (ECC, HMAC, MLDSA and similar) and fetches one key entry, dword by dword, over the keyvault read port.
- Each returned dword is written into the engine's local key register. On completion it reports done and status to the engine's control logic.
- It is the requesting end of the keyvault read interface; the keyvault storage array is the responder.

Parameters:
- KV_ENTRY_ADDR_W, 5, width of the key entry index.
- KV_ENTRY_SIZE_W, 4, width of the dword offset within an entry (max 16 dwords).
- DEST_NUM_DWORDS, 12, capacity of the destination key register in dwords (1..2**KV_ENTRY_SIZE_W).
- DEST_OFFSET_W, $clog2(DEST_NUM_DWORDS), width of the destination dword offset.

Ports:
- clk  in  1  clock.
- rst_b  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous abort and zeroize (debug/scan flush).
- start  in  1  single-cycle pulse to begin a fetch.
- start_entry  in  KV_ENTRY_ADDR_W  entry to fetch; sampled when start is accepted.
- ready  out  1  idle and able to accept start.
- done  out  1  one-cycle pulse when the fetch ends, whether it succeeded or failed.
- error_code  out  8  status: 0x00 OK, 0x01 READ_FAIL, 0x02 SIZE_OVERFLOW; sticky until the next accepted start.
- kv_read_entry  out  KV_ENTRY_ADDR_W  keyvault read entry.
- kv_read_offset  out  KV_ENTRY_SIZE_W  keyvault read dword offset.
- kv_rd_data  in  32  read data; combinational response to the current entry/offset.
- kv_rd_error  in  1  entry is use-locked or this client is not a valid destination.
- kv_rd_last  in  1  current offset equals the entry's stored last dword.
- dest_wr_en  out  1  write strobe to the destination key register.
- dest_wr_offset  out  DEST_OFFSET_W  destination dword index.
- dest_wr_data  out  32  destination write data.
- dest_clear  out  1  one-cycle pulse that zeroizes the whole destination register.

Behaviour:
- Reset values: ready=1; done, dest_wr_en, dest_clear=0; error_code=0x00; kv_read_entry, kv_read_offset, dest_wr_offset, dest_wr_data=0. State is IDLE and the counter is 0.
- FSM states are IDLE, READ and DONE.
- IDLE:
  - ready=1.
  - When start=1 and flush=0: latch start_entry, clear error_code to 0x00, set cnt=0, go to READ.
  - kv_read_entry and kv_read_offset are driven 0.
- READ (one dword per cycle):
  - Drive kv_read_entry=latched entry and kv_read_offset=cnt.
  - The response is sampled in the same cycle.
  - If kv_rd_error=1:
    - dest_wr_en=0 and dest_clear=1 in this cycle.
    - error_code<=0x01; go to DONE.
  - Else:
    - dest_wr_en=1, dest_wr_offset=cnt[DEST_OFFSET_W-1:0], dest_wr_data=kv_rd_data.
    - If kv_rd_last=1: go to DONE with OK.
    - Else if cnt==DEST_NUM_DWORDS-1: the entry is longer than the destination. dest_clear pulses in the next cycle (DONE), error_code<=0x02, go to DONE.
    - Else cnt<=cnt+1.
  - The final dword is always written before leaving READ.
  - A last asserted on cnt < DEST_NUM_DWORDS-1 is a legal short key; unwritten destination dwords keep their prior value. Engines that need zero padding must clear before start.
- DONE:
  - done=1 for exactly one cycle; dest_clear=1 here if SIZE_OVERFLOW.
  - Next state IDLE. ready=0 in DONE, so the earliest next start is the cycle after done.
- Latency: a successful fetch of N dwords takes N READ cycles plus 1 DONE cycle. start at cycle 0 gives dwords written in cycles 1..N and done in cycle N+1.
- start while not in IDLE is ignored. The latched entry is not altered mid-fetch.
- flush=1 in any state:
  - Next state IDLE, cnt=0, error_code=0x00.
  - dest_wr_en forced 0 in that cycle; dest_clear=1 in that cycle; done not asserted.
  - flush takes priority over start and over every READ transition.
- Counter width is KV_ENTRY_SIZE_W, with no wrap: the SIZE_OVERFLOW check ends the fetch before wrap, because DEST_NUM_DWORDS ≤ 2**KV_ENTRY_SIZE_W.
- Reset asserted mid-fetch returns the block to reset values immediately. The destination is not cleared by this block on reset; the destination owns its own reset.
- dest_wr_data must be 0 whenever dest_wr_en=0, so no key data appears on an idle bus.

Test Plan:
- Entry 3 holds 12 dwords 0xA0..0xAB, with last at offset 11 and this client valid; start_entry=3 → dest writes at offsets 0..11 with 0xA0..0xAB in 12 consecutive cycles, done in cycle 13, error_code=0x00, dest_clear never asserted.
- Entry 5 holds 8 dwords with last at offset 7 → 8 writes, done at cycle 9, OK, offsets 8..11 untouched.
- kv_rd_error=1 at offset 4 (use-lock asserted mid-fetch) → writes 0..3 only, dest_clear pulse in that cycle, done next cycle, error_code=0x01 held until the next start.
- Entry last at offset 15 with DEST_NUM_DWORDS=12 → writes 0..11, dest_clear and done in cycle 13, error_code=0x02.
- flush at the 6th READ cycle → no write that cycle, dest_clear=1, ready=1 next cycle, no done, error_code=0x00; a start in the flush cycle is ignored.
- start pulsed again during READ, and start applied in the DONE cycle → both ignored, fetch entry unchanged; a start the cycle after done is accepted.
